// File: rtl/pet_memmap_if.sv
// CPU bus of the PET memory map: cycle strobe, address, write data/enable and
// the registered read data returned by the decoder.
`timescale 1ns/1ps
interface pet_memmap_if;
  logic        ce_1m;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        we;
  logic [7:0]  data_out;

  modport master (output ce_1m, addr, data_in, we, input data_out);
  modport slave  (input ce_1m, addr, data_in, we, output data_out);
endinterface

// File: rtl/pet_memmap.sv
// PET memory map: address decode for RAM / VRAM / ROM / I/O, registered CPU
// read data, and a RAM port arbiter that lets DMA use cycles the CPU leaves free.
// Optional 8296-style bank register at $FFF0 is built when PET_BANKSW_EN is defined.
`timescale 1ns/1ps
module pet_memmap #(
  parameter int unsigned RAM_KB    = 32,
  parameter int unsigned VRAM_AW   = 11,
  parameter logic [7:0]  UNMAP_VAL = 8'h55
) (
  input  logic               clk,
  input  logic               reset,
  pet_memmap_if.slave        cpu,
  output logic [16:0]        ram_addr,
  output logic [7:0]         ram_din,
  output logic               ram_we,
  input  logic [7:0]         ram_q,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  input  logic [7:0]         vram_q,
  output logic [13:0]        rom_addr,
  input  logic [7:0]         rom_q,
  output logic               io_we,
  input  logic [7:0]         io_q,
  input  logic               dma_req,
  input  logic [16:0]        dma_addr,
  input  logic [7:0]         dma_din,
  input  logic               dma_we,
  output logic               dma_ack,
  output logic [7:0]         dma_dout
);

  localparam int unsigned RAM_BYTES = RAM_KB * 1024;

  typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_DMA} arb_e;
  typedef enum logic [2:0] {SRC_NONE, SRC_RAM, SRC_VRAM, SRC_ROM, SRC_IO} src_e;

  arb_e        state_q, state_d;
  src_e        src_q, src_d, cpu_src;
  logic        rd_q, rd_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        dma_grant;
  logic        cpu_wr;
  logic        in_ram, in_vram, in_io, in_rom;
  logic        keep_io, map_hi, hi_bank, hi_wp;
  logic [16:0] cpu_ram_addr;
  logic [7:0]  bank_cfg;
  logic        bank_wr;

  assign cpu_wr = cpu.ce_1m && cpu.we && !reset;

`ifdef PET_BANKSW_EN
  logic [7:0] bank_q, bank_d;

  // Bank control register, written by the CPU at $FFF0
  always_comb begin
    bank_wr  = cpu_wr && (cpu.addr == 16'hFFF0);
    bank_d   = bank_wr ? cpu.data_in : bank_q;
    bank_cfg = bank_q;
  end

  // Bank register state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bank_q <= '0;
    else       bank_q <= bank_d;
  end
`else
  // No bank register: upper 32 KB never remapped
  always_comb begin
    bank_wr  = 1'b0;
    bank_cfg = '0;
  end
`endif

  // Address decode of the current CPU cycle, including bank remapping
  always_comb begin
    in_ram  = ({16'h0000, cpu.addr} < RAM_BYTES);
    in_vram = (cpu.addr[15:12] == 4'h8);
    in_io   = (cpu.addr[15:11] == 5'b11101);
    in_rom  = ((cpu.addr >= 16'h9000) && (cpu.addr <= 16'hE7FF)) ||
              (cpu.addr[15:12] == 4'hF);
    keep_io = bank_cfg[6] && (in_vram || in_io);
    map_hi  = bank_cfg[7] && cpu.addr[15] && !keep_io;
    hi_bank = cpu.addr[14] ? bank_cfg[3] : bank_cfg[2];
    hi_wp   = map_hi && (cpu.addr[14] ? bank_cfg[1] : bank_cfg[0]);
    cpu_src = SRC_NONE;
    if (map_hi)       cpu_src = SRC_RAM;
    else if (in_ram)  cpu_src = SRC_RAM;
    else if (in_vram) cpu_src = SRC_VRAM;
    else if (in_io)   cpu_src = SRC_IO;
    else if (in_rom)  cpu_src = SRC_ROM;
    cpu_ram_addr = map_hi ? {1'b1, hi_bank, cpu.addr[14:0]}
                          : {2'b00, cpu.addr[14:0]};
  end

  // Arbiter next state: CPU cycles always win, DMA takes the next free cycle
  always_comb begin
    state_d   = ST_IDLE;
    dma_grant = 1'b0;
    if (cpu.ce_1m) begin
      state_d = ST_CPU;
    end else if (dma_req && (state_q != ST_DMA)) begin
      state_d   = ST_DMA;
      dma_grant = 1'b1;
    end
  end

  // RAM, VRAM and I/O port drive; strobes held low during reset
  always_comb begin
    ram_addr = cpu_ram_addr;
    ram_din  = cpu.data_in;
    ram_we   = cpu_wr && (cpu_src == SRC_RAM) && !hi_wp && !bank_wr;
    if (dma_grant) begin
      ram_addr = dma_addr;
      ram_din  = dma_din;
      ram_we   = dma_we && !reset;
    end
    vram_we = cpu_wr && (cpu_src == SRC_VRAM);
    io_we   = cpu_wr && (cpu_src == SRC_IO);
  end

  assign vram_addr    = cpu.addr[VRAM_AW-1:0];
  assign rom_addr     = cpu.addr[13:0];
  assign dma_ack      = (state_q == ST_DMA);
  assign dma_dout     = dma_ack ? ram_q : 8'h00;
  assign cpu.data_out = data_out_q;

  // Read pipeline: remember the source in the strobe cycle, load data a cycle later
  always_comb begin
    rd_d       = cpu.ce_1m && !cpu.we;
    src_d      = cpu_src;
    data_out_d = data_out_q;
    if (rd_q) begin
      case (src_q)
        SRC_RAM:  data_out_d = ram_q;
        SRC_VRAM: data_out_d = vram_q;
        SRC_ROM:  data_out_d = rom_q;
        SRC_IO:   data_out_d = io_q;
        default:  data_out_d = UNMAP_VAL;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_q       <= 1'b0;
      src_q      <= SRC_NONE;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      src_q      <= src_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: tb/tb_pet_memmap.sv
// Self-checking bench for pet_memmap (RAM_KB=8, VRAM_AW=10) with simple
// synchronous memory models and a read-data scoreboard.
`timescale 1ns/1ps
module tb_pet_memmap;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pet_memmap_if cpu_if ();

  logic [16:0] ram_addr;
  logic [7:0]  ram_din, ram_q, vram_q, rom_q, io_q, dma_din, dma_dout;
  logic        ram_we, vram_we, io_we, dma_req, dma_we, dma_ack;
  logic [9:0]  vram_addr;
  logic [13:0] rom_addr;
  logic [16:0] dma_addr;

  pet_memmap #(.RAM_KB(8), .VRAM_AW(10), .UNMAP_VAL(8'h55)) dut (
    .clk(clk), .reset(reset), .cpu(cpu_if),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_q(vram_q),
    .rom_addr(rom_addr), .rom_q(rom_q), .io_we(io_we), .io_q(io_q),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
    .dma_ack(dma_ack), .dma_dout(dma_dout)
  );

  int checks = 0;
  int fails  = 0;

  function automatic logic [7:0] ram_init(input int unsigned i);
    return 8'((i * 7 + 3) ^ (i >> 8));
  endfunction
  function automatic logic [7:0] rom_fn(input logic [13:0] x);
    return x[7:0] ^ {x[13:8], 2'b10};
  endfunction

  // Memory models seen by the DUT
  logic [7:0] ram_mem [0:131071];
  logic [7:0] vram_mem [0:1023];
  logic [7:0] io_reg;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_q <= ram_mem[ram_addr];
    if (vram_we) vram_mem[vram_addr] <= cpu_if.data_in;
    vram_q <= vram_mem[vram_addr];
    if (io_we) io_reg <= cpu_if.data_in;
    io_q  <= io_reg;
    rom_q <= rom_fn(rom_addr);
  end

  // Reference contents for expected read data
  logic [7:0] ref_ram [0:8191];
  logic [7:0] ref_vram [0:1023];
  logic [7:0] ref_io;

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    if (a < 16'h2000) return ref_ram[a[12:0]];
    if (a[15:12] == 4'h8) return ref_vram[a[9:0]];
    if (a >= 16'hE800 && a <= 16'hEFFF) return ref_io;
    if (a >= 16'h9000) return rom_fn(a[13:0]);
    return 8'h55;
  endfunction

  // Scoreboard: expected read data queued at issue, checked when data_out loads
  logic [7:0]  exp_q [$];
  logic [15:0] exp_a [$];
  logic rd_p1, rd_p2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_p1 <= 1'b0;
      rd_p2 <= 1'b0;
    end else begin
      rd_p1 <= cpu_if.ce_1m && !cpu_if.we;
      rd_p2 <= rd_p1;
    end
  end
  always @(negedge clk) begin
    if (rd_p2) begin
      logic [7:0]  e;
      logic [15:0] a;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL read_data: data_out %h produced with no read outstanding", cpu_if.data_out);
      end else begin
        e = exp_q.pop_front();
        a = exp_a.pop_front();
        if (cpu_if.data_out !== e) begin
          fails++;
          $display("FAIL read_data @%h: got %h, required %h", a, cpu_if.data_out, e);
        end
      end
    end
  end

  task automatic cpu_start(input logic [15:0] a, input logic w, input logic [7:0] d);
    @(negedge clk);
    cpu_if.ce_1m = 1'b1; cpu_if.addr = a; cpu_if.we = w; cpu_if.data_in = d;
    if (!w) begin
      exp_q.push_back(exp_read(a));
      exp_a.push_back(a);
    end else if (a < 16'h2000) ref_ram[a[12:0]] = d;
    else if (a[15:12] == 4'h8) ref_vram[a[9:0]] = d;
    else if (a >= 16'hE800 && a <= 16'hEFFF) ref_io = d;
    #1;
  endtask

  task automatic cpu_end();
    @(negedge clk);
    cpu_if.ce_1m = 1'b0; cpu_if.we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (cpu_if.data_out !== 8'h00) begin fails++; $display("FAIL rst_data_out: got %h, required 00", cpu_if.data_out); end
    checks++; if (dma_ack !== 1'b0) begin fails++; $display("FAIL rst_dma_ack: got %b, required 0", dma_ack); end
    checks++; if (dma_dout !== 8'h00) begin fails++; $display("FAIL rst_dma_dout: got %h, required 00", dma_dout); end
    cpu_if.ce_1m = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 16'h0010; cpu_if.data_in = 8'hEE; #1;
    checks++; if (ram_we !== 1'b0) begin fails++; $display("FAIL rst_ram_we: got %b, required 0", ram_we); end
    cpu_if.addr = 16'h8001; #1;
    checks++; if (vram_we !== 1'b0) begin fails++; $display("FAIL rst_vram_we: got %b, required 0", vram_we); end
    cpu_if.addr = 16'hE810; #1;
    checks++; if (io_we !== 1'b0) begin fails++; $display("FAIL rst_io_we: got %b, required 0", io_we); end
    cpu_if.ce_1m = 1'b0; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 17'h00010; #1;
    checks++; if (ram_we !== 1'b0) begin fails++; $display("FAIL rst_dma_we: got %b, required 0", ram_we); end
    @(negedge clk);
    checks++; if (dma_ack !== 1'b0) begin fails++; $display("FAIL rst_dma_ack2: got %b, required 0", dma_ack); end
    dma_req = 1'b0; dma_we = 1'b0; cpu_if.we = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_ram();
    cpu_start(16'h1FFF, 1'b1, 8'hA5);
    checks++; if (ram_we !== 1'b1) begin fails++; $display("FAIL ram_we_1fff: got %b, required 1", ram_we); end
    checks++; if (ram_addr !== 17'h01FFF) begin fails++; $display("FAIL ram_addr_1fff: got %h, required 01fff", ram_addr); end
    checks++; if (ram_din !== 8'hA5) begin fails++; $display("FAIL ram_din_1fff: got %h, required a5", ram_din); end
    cpu_end();
    cpu_start(16'h1FFF, 1'b0, 8'h00); cpu_end();
    cpu_start(16'h2000, 1'b1, 8'h33);
    checks++; if (ram_we !== 1'b0) begin fails++; $display("FAIL ram_we_2000: got %b, required 0", ram_we); end
    cpu_end();
    cpu_start(16'h2000, 1'b0, 8'h00); cpu_end();
    cpu_start(16'h0000, 1'b0, 8'h00); cpu_end();
    cpu_start(16'h7FFF, 1'b0, 8'h00); cpu_end();
  endtask

  task automatic test_decode();
    cpu_start(16'h8400, 1'b1, 8'h3C);
    checks++; if (vram_we !== 1'b1) begin fails++; $display("FAIL vram_we_8400: got %b, required 1", vram_we); end
    checks++; if (vram_addr !== 10'h000) begin fails++; $display("FAIL vram_addr_8400: got %h, required 000", vram_addr); end
    checks++; if (ram_we !== 1'b0) begin fails++; $display("FAIL ram_we_8400: got %b, required 0", ram_we); end
    cpu_end();
    cpu_start(16'h8000, 1'b0, 8'h00); cpu_end();
    cpu_start(16'h8FFF, 1'b0, 8'h00); cpu_end();
    cpu_start(16'hF000, 1'b0, 8'h00); cpu_end();
    cpu_start(16'h9000, 1'b0, 8'h00); cpu_end();
    cpu_start(16'hE7FF, 1'b0, 8'h00); cpu_end();
    cpu_start(16'h9000, 1'b1, 8'h12);
    checks++; if ({ram_we, vram_we, io_we} !== 3'b000) begin fails++; $display("FAIL rom_write: strobes %b, required 000", {ram_we, vram_we, io_we}); end
    cpu_end();
    cpu_start(16'hE800, 1'b1, 8'h6B);
    checks++; if (io_we !== 1'b1) begin fails++; $display("FAIL io_we_e800: got %b, required 1", io_we); end
    cpu_end();
    cpu_start(16'hEFFF, 1'b0, 8'h00); cpu_end();
  endtask

`ifdef PET_BANKSW_EN
  task automatic test_bank();
    cpu_start(16'hFFF0, 1'b1, 8'h8C); cpu_end();
    cpu_start(16'hC123, 1'b1, 8'h11);
    checks++; if (ram_addr !== 17'h1C123) begin fails++; $display("FAIL bank_addr_c123: got %h, required 1c123", ram_addr); end
    checks++; if (ram_we !== 1'b1) begin fails++; $display("FAIL bank_we_c123: got %b, required 1", ram_we); end
    cpu_end();
    cpu_start(16'hFFF0, 1'b1, 8'h8E); cpu_end();
    cpu_start(16'hC123, 1'b1, 8'h22);
    checks++; if (ram_we !== 1'b0) begin fails++; $display("FAIL bank_wp_c123: got %b, required 0", ram_we); end
    cpu_end();
    cpu_start(16'hFFF0, 1'b1, 8'hC0); cpu_end();
    cpu_start(16'h8010, 1'b1, 8'h44);
    checks++; if ({ram_we, vram_we} !== 2'b01) begin fails++; $display("FAIL bank_keep_vram: ram/vram we %b, required 01", {ram_we, vram_we}); end
    cpu_end();
    cpu_start(16'hFFF0, 1'b1, 8'h80); cpu_end();
    cpu_start(16'hA010, 1'b1, 8'h45);
    checks++; if (ram_addr !== 17'h12010) begin fails++; $display("FAIL bank_addr_a010: got %h, required 12010", ram_addr); end
    cpu_end();
    cpu_start(16'hFFF0, 1'b1, 8'h00); cpu_end();
    cpu_start(16'hFFF0, 1'b0, 8'h00); cpu_end();
  endtask
`else
  task automatic test_no_bank();
    cpu_start(16'hFFF0, 1'b1, 8'h8C);
    checks++; if ({ram_we, vram_we, io_we} !== 3'b000) begin fails++; $display("FAIL fff0_write: strobes %b, required 000", {ram_we, vram_we, io_we}); end
    cpu_end();
    cpu_start(16'hC123, 1'b1, 8'h11);
    checks++; if (ram_we !== 1'b0) begin fails++; $display("FAIL nobank_we_c123: got %b, required 0", ram_we); end
    checks++; if (ram_addr[16:15] !== 2'b00) begin fails++; $display("FAIL nobank_addr_hi: got %b, required 00", ram_addr[16:15]); end
    cpu_end();
    cpu_start(16'hFFF0, 1'b0, 8'h00); cpu_end();
  endtask
`endif

  task automatic test_dma_coincident();
    cpu_start(16'h1000, 1'b1, 8'h4D); cpu_end();
    cpu_start(16'h0123, 1'b1, 8'h77); cpu_end();
    cpu_start(16'h1000, 1'b0, 8'h00);
    dma_req = 1'b1; dma_addr = 17'h00123; dma_we = 1'b0; #1;
    checks++; if (ram_addr !== 17'h01000) begin fails++; $display("FAIL coin_cpu_addr: got %h, required 01000", ram_addr); end
    checks++; if (dma_ack !== 1'b0) begin fails++; $display("FAIL coin_ack0: got %b, required 0", dma_ack); end
    cpu_end(); #1;
    checks++; if (ram_addr !== 17'h00123) begin fails++; $display("FAIL coin_grant_addr: got %h, required 00123", ram_addr); end
    checks++; if (dma_ack !== 1'b0) begin fails++; $display("FAIL coin_ack1: got %b, required 0", dma_ack); end
    @(negedge clk); dma_req = 1'b0; #1;
    checks++; if (dma_ack !== 1'b1) begin fails++; $display("FAIL coin_ack2: got %b, required 1", dma_ack); end
    checks++; if (dma_dout !== 8'h77) begin fails++; $display("FAIL coin_dout: got %h, required 77", dma_dout); end
    @(negedge clk); #1;
    checks++; if (dma_ack !== 1'b0) begin fails++; $display("FAIL coin_ack3: got %b, required 0", dma_ack); end
  endtask

  task automatic test_dma_write();
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 17'h00200; dma_din = 8'h9A; #1;
    checks++; if (ram_we !== 1'b1) begin fails++; $display("FAIL dmaw_we: got %b, required 1", ram_we); end
    checks++; if (ram_addr !== 17'h00200) begin fails++; $display("FAIL dmaw_addr: got %h, required 00200", ram_addr); end
    ref_ram[13'h0200] = 8'h9A;
    @(negedge clk); dma_req = 1'b0; dma_we = 1'b0; #1;
    checks++; if (dma_ack !== 1'b1) begin fails++; $display("FAIL dmaw_ack: got %b, required 1", dma_ack); end
    @(negedge clk); #1;
    checks++; if (dma_ack !== 1'b0) begin fails++; $display("FAIL dmaw_ack_end: got %b, required 0", dma_ack); end
    cpu_start(16'h0200, 1'b0, 8'h00); cpu_end();
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int consec = 0;
    logic prev = 1'b0;
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 17'h00123;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (dma_ack === 1'b1) begin
        acks++;
        if (prev) consec++;
        checks++; if (dma_dout !== 8'h77) begin fails++; $display("FAIL b2b_dout: got %h, required 77", dma_dout); end
      end
      prev = dma_ack;
      @(negedge clk);
    end
    dma_req = 1'b0;
    checks++; if (acks != 4) begin fails++; $display("FAIL b2b_acks: got %0d, required 4", acks); end
    checks++; if (consec != 0) begin fails++; $display("FAIL b2b_gap: got %0d back-to-back acks, required 0", consec); end
    @(negedge clk); #1;
    checks++; if (dma_ack !== 1'b0) begin fails++; $display("FAIL b2b_ack_end: got %b, required 0", dma_ack); end
  endtask

  task automatic test_dma_cancel();
    int acks = 0;
    cpu_start(16'h1000, 1'b0, 8'h00);
    dma_req = 1'b1; dma_addr = 17'h00123; dma_we = 1'b1; dma_din = 8'hFF; #1;
    checks++; if (ram_addr !== 17'h01000) begin fails++; $display("FAIL cancel_cpu_addr: got %h, required 01000", ram_addr); end
    cpu_end(); dma_req = 1'b0; dma_we = 1'b0; #1;
    checks++; if (ram_we !== 1'b0) begin fails++; $display("FAIL cancel_we: got %b, required 0", ram_we); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (dma_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin fails++; $display("FAIL cancel_acks: got %0d, required 0", acks); end
  endtask

  task automatic test_reset_grant();
    int acks = 0;
    @(negedge clk);
    dma_req = 1'b1; dma_addr = 17'h00123; dma_we = 1'b0; #1;
    checks++; if (ram_addr !== 17'h00123) begin fails++; $display("FAIL rg_grant_addr: got %h, required 00123", ram_addr); end
    #1 reset = 1'b1;
    @(negedge clk); dma_req = 1'b0; #1;
    checks++; if (dma_ack !== 1'b0) begin fails++; $display("FAIL rg_ack_in_reset: got %b, required 0", dma_ack); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (dma_ack === 1'b1) acks++;
      @(negedge clk);
    end
    checks++; if (acks != 0) begin fails++; $display("FAIL rg_acks: got %0d, required 0", acks); end
    checks++; if (cpu_if.data_out !== 8'h00) begin fails++; $display("FAIL rg_data_out: got %h, required 00", cpu_if.data_out); end
    dma_req = 1'b1; #1;
    checks++; if (ram_addr !== 17'h00123) begin fails++; $display("FAIL rg_regrant: got %h, required 00123", ram_addr); end
    @(negedge clk); dma_req = 1'b0; #1;
    checks++; if (dma_ack !== 1'b1) begin fails++; $display("FAIL rg_ack_after: got %b, required 1", dma_ack); end
    checks++; if (dma_dout !== 8'h77) begin fails++; $display("FAIL rg_dout_after: got %h, required 77", dma_dout); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cpu_if.ce_1m = 1'b0; cpu_if.addr = '0; cpu_if.data_in = '0; cpu_if.we = 1'b0;
    dma_req = 1'b0; dma_addr = '0; dma_din = '0; dma_we = 1'b0;
    io_reg = 8'h00; ref_io = 8'h00;
    for (int i = 0; i < 131072; i++) ram_mem[i] = ram_init(i);
    for (int i = 0; i < 8192; i++) ref_ram[i] = ram_init(i);
    for (int i = 0; i < 1024; i++) begin
      vram_mem[i] = 8'(i) ^ 8'hA5;
      ref_vram[i] = 8'(i) ^ 8'hA5;
    end
    test_reset();
    test_ram();
    test_decode();
`ifdef PET_BANKSW_EN
    test_bank();
`else
    test_no_bank();
`endif
    test_dma_coincident();
    test_dma_write();
    test_back_to_back();
    test_dma_cancel();
    repeat (3) @(negedge clk);
    test_reset_grant();
    repeat (3) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL read_drain: %0d reads outstanding, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
